// File: rtl/bird_pkg.sv
// Shared types and default geometry for the bird vertical-motion controller.
package bird_pkg;

    typedef enum logic [1:0] {IDLE, FLY, DEAD} bird_state_t;

    localparam int ROWS_DEF       = 16;
    localparam int START_ROW_DEF  = 7;
    localparam int RISE_STEPS_DEF = 2;

endpackage

// File: rtl/bird_motion_rise_edge.sv
// Rising-edge detector: one-cycle pulse on the first clock a level input is seen high.
module rise_edge (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic in_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/bird_motion.sv
// Bird row controller: flaps buy a few climbing steps, otherwise each game step falls one row.
module bird_motion
    import bird_pkg::*;
#(
    parameter int ROWS       = ROWS_DEF,
    parameter int START_ROW  = START_ROW_DEF,
    parameter int RISE_STEPS = RISE_STEPS_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    flap,
    output logic [$clog2(ROWS)-1:0] row,
    output logic                    alive,
    output logic                    dead,
    output logic                    step
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int CNT_W = $clog2(RISE_STEPS + 1);

    localparam logic [ROW_W-1:0] START_V  = ROW_W'(START_ROW);
    localparam logic [ROW_W-1:0] LAST_V   = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [CNT_W-1:0] RELOAD_V = CNT_W'(RISE_STEPS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    bird_state_t      state_q;
    logic [ROW_W-1:0] row_q;
    logic [CNT_W-1:0] rise_cnt_q;
    logic             alive_q;
    logic             dead_q;
    logic             step_q;
    logic             tick_rise;
    logic             flap_rise;

    rise_edge u_tick_edge (
        .clk   (clk),
        .reset (reset),
        .in    (tick),
        .pulse (tick_rise)
    );

    rise_edge u_flap_edge (
        .clk   (clk),
        .reset (reset),
        .in    (flap),
        .pulse (flap_rise)
    );

    // alive/dead are registered alongside the state so they never glitch or overlap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            row_q      <= START_V;
            rise_cnt_q <= '0;
            alive_q    <= 1'b0;
            dead_q     <= 1'b0;
            step_q     <= 1'b0;
        end else begin
            step_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    row_q <= START_V;
                    if (flap_rise) begin
                        state_q    <= FLY;
                        rise_cnt_q <= RELOAD_V;
                        alive_q    <= 1'b1;
                    end
                end
                FLY: begin
                    if (tick_rise) begin
                        step_q <= 1'b1;
                        // A flap landing on the same step reloads before this step consumes one.
                        if (rise_cnt_q != '0 || flap_rise) begin
                            row_q      <= (row_q == '0) ? '0 : row_q - ROW_ONE;
                            rise_cnt_q <= flap_rise ? RELOAD_V - CNT_ONE
                                                    : rise_cnt_q - CNT_ONE;
                        end else if (row_q == LAST_V) begin
                            state_q <= DEAD;
                            alive_q <= 1'b0;
                            dead_q  <= 1'b1;
                        end else begin
                            row_q <= row_q + ROW_ONE;
                        end
                    end else if (flap_rise) begin
                        rise_cnt_q <= RELOAD_V;
                    end
                end
                DEAD: begin
                    if (flap_rise) begin
                        state_q    <= IDLE;
                        row_q      <= START_V;
                        rise_cnt_q <= '0;
                        dead_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    alive_q <= 1'b0;
                    dead_q  <= 1'b0;
                end
            endcase
        end
    end

    assign row   = row_q;
    assign alive = alive_q;
    assign dead  = dead_q;
    assign step  = step_q;

endmodule

// File: tb/tb_bird_motion.sv
// Scoreboard bench for bird_motion: a game-rules model queues the expected row/status per step pulse.
module tb_bird_motion;

    localparam int ROWS       = 16;
    localparam int START_ROW  = 7;
    localparam int RISE_STEPS = 2;

    localparam int M_IDLE = 0;
    localparam int M_FLY  = 1;
    localparam int M_DEAD = 2;

    typedef struct {
        int row;
        int alive;
        int dead;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       flap;
    logic [3:0] row;
    logic       alive;
    logic       dead;
    logic       step;

    exp_t expQ[$];
    int   passCount  = 0;
    int   totalCount = 0;
    int   mState;
    int   mRow;
    int   mCredits;

    bird_motion #(
        .ROWS       (ROWS),
        .START_ROW  (START_ROW),
        .RISE_STEPS (RISE_STEPS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .flap  (flap),
        .row   (row),
        .alive (alive),
        .dead  (dead),
        .step  (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input int act, input int exp);
        totalCount++;
        if (act == exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mState   = M_IDLE;
        mRow     = START_ROW;
        mCredits = 0;
        expQ.delete();
    endtask

    // Game rules: a flap grants RISE_STEPS climbing steps, every other step falls one row.
    task automatic modelUpdate(input bit f, input bit t);
        exp_t e;
        case (mState)
            M_IDLE: begin
                if (f) begin
                    mState   = M_FLY;
                    mCredits = RISE_STEPS;
                end
            end
            M_FLY: begin
                if (f) mCredits = RISE_STEPS;
                if (t) begin
                    if (mCredits > 0) begin
                        mCredits = mCredits - 1;
                        mRow     = (mRow > 0) ? mRow - 1 : 0;
                    end else if (mRow == ROWS - 1) begin
                        mState = M_DEAD;
                    end else begin
                        mRow = mRow + 1;
                    end
                    e.row   = mRow;
                    e.alive = (mState == M_FLY) ? 1 : 0;
                    e.dead  = (mState == M_DEAD) ? 1 : 0;
                    expQ.push_back(e);
                end
            end
            default: begin
                if (f) begin
                    mState   = M_IDLE;
                    mRow     = START_ROW;
                    mCredits = 0;
                end
            end
        endcase
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".row"}, int'(row), mRow);
        checkVal({tag, ".alive"}, int'(alive), (mState == M_FLY) ? 1 : 0);
        checkVal({tag, ".dead"}, int'(dead), (mState == M_DEAD) ? 1 : 0);
        checkVal({tag, ".stepIdle"}, int'(step), 0);
    endtask

    // One game-input event: both edges presented together for one clock, then released.
    task automatic applyStimulus(input bit f, input bit t);
        flap = f;
        tick = t;
        @(posedge clk);
        #1;
        modelUpdate(f, t);
        flap = 1'b0;
        tick = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("op");
    endtask

    task automatic holdTick(input int cycles);
        tick = 1'b1;
        @(posedge clk);
        #1;
        modelUpdate(1'b0, 1'b1);
        repeat (cycles - 1) @(posedge clk);
        #1;
        tick = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("hold");
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset && step) begin
            if (expQ.size() == 0) begin
                checkVal("unexpectedStep", 1, 0);
            end else begin
                e = expQ.pop_front();
                checkVal("sb.row", int'(row), e.row);
                checkVal("sb.alive", int'(alive), e.alive);
                checkVal("sb.dead", int'(dead), e.dead);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        tick  = 1'b0;
        flap  = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");

        // Release reset with tick already high; that edge must be absorbed in IDLE.
        tick  = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("releaseHigh");

        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1);
        checkVal("idleRow", int'(row), START_ROW);

        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1);
        checkVal("fallRow", int'(row), 9);

        for (int i = 0; i < 20 && mState == M_FLY; i++) applyStimulus(1'b0, 1'b1);
        checkVal("deadFlag", int'(dead), 1);
        checkVal("deadRow", int'(row), ROWS - 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
        checkVal("deadFrozen", int'(row), ROWS - 1);

        applyStimulus(1'b1, 1'b0);
        checkVal("restartRow", int'(row), START_ROW);

        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 10 && mRow > 1; i++) applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
        checkVal("ceilingRow", int'(row), 0);

        for (int i = 0; i < 20 && !(mRow == 8 && mCredits == 0); i++) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkVal("simulRow", int'(row), 7);
        applyStimulus(1'b0, 1'b1);
        checkVal("simulNext", int'(row), 6);
        applyStimulus(1'b0, 1'b1);
        checkVal("simulFall", int'(row), 7);

        for (int i = 0; i < 20 && mRow != 10; i++) applyStimulus(1'b0, 1'b1);
        checkVal("preResetRow", int'(row), 10);
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        checkOutput("asyncReset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("afterRelease");

        holdTick(6);
        applyStimulus(1'b1, 1'b0);
        holdTick(6);

        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r >= 97) begin
                holdTick($urandom_range(2, 5));
            end else begin
                applyStimulus(r < 22, $urandom_range(0, 3) != 0);
            end
        end

        @(posedge clk);
        #1;
        checkVal("queueEmpty", expQ.size(), 0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
